dp_seq_core: RTL and testbench
==============================

// Module: dp_seq_core
// PURPOSE
//  Parametrised multi-cycle datapath: WIDTH-bit, NREGS-entry register file, A/B/C pipeline registers,
//  shifter, 4-op ALU and N/V/Z status, driven by one registered command per valid/ready handshake.
//  An internal FSM sequences register reads, execute and writeback, so the controller issues
//  one command per operation instead of individual load strobes. Sits between decoder/controller and memory.
// PARAMETERS
//  WIDTH   16  datapath, register and immediate width (>=4)
//  NREGS   8   register count, power of 2 (>=2); RAW=$clog2(NREGS)
//  PCW     8   PC width, <= WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      core can accept; high only in IDLE
//  cmd_rn     in   RAW    A operand register
//  cmd_rm     in   RAW    B operand register
//  cmd_rd     in   RAW    writeback register
//  cmd_shift  in   2      00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
//  cmd_aluop  in   2      00 ADD, 01 SUB, 10 AND, 11 NOT B
//  cmd_asel   in   1      1: A operand forced to 0
//  cmd_bsel   in   1      1: B operand = cmd_imm5 (shifter bypassed)
//  cmd_vsel   in   2      writeback src: 00 C, 01 zero-ext pc, 10 cmd_imm8, 11 mdata
//  cmd_wb     in   1      write result to cmd_rd
//  cmd_loads  in   1      update status from this ALU result
//  cmd_imm8   in   WIDTH  sign-extended 8-bit immediate
//  cmd_imm5   in   WIDTH  sign-extended 5-bit immediate
//  mdata      in   WIDTH  memory read data, sampled in WB
//  pc         in   PCW    program counter, sampled in WB
//  done       out  1      one-cycle pulse: command completed
//  out        out  WIDTH  C register
//  N,V,Z      out  1      status flags (registered)
// BEHAVIOUR
//  Reset: FSM->IDLE, all registers incl. regfile = 0; cmd_ready=1, done=0, out=0, N=V=Z=0.
//  Accept when cmd_valid&&cmd_ready at a clk edge; all cmd_* captured; inputs ignored until IDLE again.
//  FSM (vsel==00): IDLE->RDA->RDB->EXEC->WB->IDLE. RDA: A<=R[rn]. RDB: B<=R[rm].
//   EXEC: C<=ALU(A',B'); if loads, {N,V,Z}<=flags. WB: if wb, R[rd]<=C; done=1.
//  FSM (vsel!=00): IDLE->WB->IDLE; A,B,C,status untouched; WB writes selected source if wb.
//  Latency: done high 4 cycles after accept (ALU), 1 cycle (direct). Back-to-back: next accept in cycle after WB.
//  A'=asel?0:A. B'=bsel?imm5:shift(B). All arithmetic mod 2^WIDTH.
//  Z=(result==0); N=result[WIDTH-1]; V: ADD signed overflow, SUB signed overflow of A'-B', else 0.
//  Read-after-write: RDA/RDB of a later command see WB of an earlier one (no overlap by construction).
//  rn==rm, rd==rn legal; wb=0 with vsel!=00 completes as a no-op with done pulse.
//  reset mid-command: aborts at that edge, no writeback, no done.
// CONFIGURATION
//  DP_SAT_EN defined: ADD/SUB saturate to signed max/min on overflow; V still reports overflow.
//  DP_SAT_EN undefined: ADD/SUB wrap modulo 2^WIDTH.
// STRUCTURE
//  Package dp_pkg: aluop_e, shift_e, vsel_e, state_e (IDLE,RDA,RDB,EXEC,WB) enums.
//  Sub-module dp_regfile #(WIDTH,NREGS): 1 write, 1 read port, sync write, comb read, sync reset.
//  Shifter, ALU, muxes and FSM inline in dp_seq_core.
// TESTING
//  Reset then imm8=0x0007 vsel=10 wb rd=R0 -> done 1 cycle after accept, R0=0x0007, out=0.
//  R1=2,R2=3; ADD rn=R1 rm=R2 shift=01 loads wb rd=R3 -> done at +4, R3=8, out=8, NZV=000.
//  R4=0x7FFF,R5=1; ADD loads -> out=0x8000, N=1 V=1 Z=0 (DP_SAT_EN: out=0x7FFF, V=1).
//  SUB rn=rm=R1 loads wb=0 -> out=0, Z=1, regfile unchanged; then NOT B of 0 -> 0xFFFF, loads=0 keeps Z=1.
//  cmd_valid held during a command -> cmd_ready=0 RDA..WB, exactly one accept per IDLE cycle.
//  reset asserted in EXEC -> next cycle IDLE, cmd_ready=1, R[rd] not written, no done pulse.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared encodings for the sequenced datapath core: command field enums and FSM states.
package dp_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOTB = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    VS_C   = 2'b00,
    VS_PC  = 2'b01,
    VS_IMM = 2'b10,
    VS_MEM = 2'b11
  } vsel_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_e;

endpackage

// File: rtl/dp_regfile.sv
// NREGS x WIDTH register file: one synchronous write port, one combinational read port.
module dp_regfile #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  localparam int RAW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [RAW-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RAW-1:0]   raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [NREGS-1:0][WIDTH-1:0] regs;

  always_ff @(posedge clk) begin
    if (reset)   regs <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/dp_seq_core.sv
// Multi-cycle datapath: one accepted command runs RDA/RDB/EXEC/WB (or a direct WB).
// Optional DP_SAT_EN: ADD/SUB saturate to signed max/min on overflow.
module dp_seq_core
  import dp_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  parameter  int PCW   = 8,
  localparam int RAW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [RAW-1:0]   cmd_rn,
  input  logic [RAW-1:0]   cmd_rm,
  input  logic [RAW-1:0]   cmd_rd,
  input  logic [1:0]       cmd_shift,
  input  logic [1:0]       cmd_aluop,
  input  logic             cmd_asel,
  input  logic             cmd_bsel,
  input  logic [1:0]       cmd_vsel,
  input  logic             cmd_wb,
  input  logic             cmd_loads,
  input  logic [WIDTH-1:0] cmd_imm8,
  input  logic [WIDTH-1:0] cmd_imm5,
  input  logic [WIDTH-1:0] mdata,
  input  logic [PCW-1:0]   pc,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             N,
  output logic             V,
  output logic             Z
);

  state_e state_q, state_d;

  logic [RAW-1:0]   rn_q, rm_q, rd_q;
  shift_e           sh_q;
  aluop_e           op_q;
  vsel_e            vsel_q;
  logic             asel_q, bsel_q, wb_q, loads_q;
  logic [WIDTH-1:0] imm8_q, imm5_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic             n_q, v_q, z_q;

  logic [RAW-1:0]   rf_raddr;
  logic [WIDTH-1:0] rf_rdata, wb_data;
  logic             rf_we;

  logic [WIDTH-1:0] a_op, b_sh, b_op, sum, diff, alu_y;
  logic             alu_v;

  // FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid) state_d = (vsel_e'(cmd_vsel) == VS_C) ? RDA : WB;
      RDA:  state_d = RDB;
      RDB:  state_d = EXEC;
      EXEC: state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  // Reset aborts the WB cycle too, so the pulse is masked by the reset it loses to.
  assign done      = (state_q == WB) && !reset;

  // Single read port is time-shared: rn in RDA, rm in RDB.
  assign rf_raddr = (state_q == RDB) ? rm_q : rn_q;

  always_comb begin
    b_sh = b_q;
    case (sh_q)
      SH_NONE: b_sh = b_q;
      SH_LSL1: b_sh = {b_q[WIDTH-2:0], 1'b0};
      SH_LSR1: b_sh = {1'b0, b_q[WIDTH-1:1]};
      SH_ASR1: b_sh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: b_sh = b_q;
    endcase
  end

  assign a_op = asel_q ? '0 : a_q;
  assign b_op = bsel_q ? imm5_q : b_sh;
  assign sum  = a_op + b_op;
  assign diff = a_op - b_op;

  always_comb begin
    alu_y = sum;
    alu_v = 1'b0;
    case (op_q)
      ALU_ADD: begin
        alu_y = sum;
        alu_v = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_op[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_y = diff;
        alu_v = (a_op[WIDTH-1] != b_op[WIDTH-1]) && (diff[WIDTH-1] != a_op[WIDTH-1]);
      end
      ALU_AND:  alu_y = a_op & b_op;
      ALU_NOTB: alu_y = ~b_op;
      default:  alu_y = sum;
    endcase
`ifdef DP_SAT_EN
    // Overflow always pushes past the limit on A's side of zero.
    if (alu_v)
      alu_y = a_op[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_comb begin
    wb_data = c_q;
    case (vsel_q)
      VS_C:    wb_data = c_q;
      VS_PC:   wb_data = WIDTH'(pc);
      VS_IMM:  wb_data = imm8_q;
      VS_MEM:  wb_data = mdata;
      default: wb_data = c_q;
    endcase
  end

  assign rf_we = (state_q == WB) && wb_q;

  dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .waddr (rd_q),
    .wdata (wb_data),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      sh_q    <= SH_NONE;
      op_q    <= ALU_ADD;
      vsel_q  <= VS_C;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      wb_q    <= 1'b0;
      loads_q <= 1'b0;
      imm8_q  <= '0;
      imm5_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_valid) begin
        rn_q    <= cmd_rn;
        rm_q    <= cmd_rm;
        rd_q    <= cmd_rd;
        sh_q    <= shift_e'(cmd_shift);
        op_q    <= aluop_e'(cmd_aluop);
        vsel_q  <= vsel_e'(cmd_vsel);
        asel_q  <= cmd_asel;
        bsel_q  <= cmd_bsel;
        wb_q    <= cmd_wb;
        loads_q <= cmd_loads;
        imm8_q  <= cmd_imm8;
        imm5_q  <= cmd_imm5;
      end
      if (state_q == RDA) a_q <= rf_rdata;
      if (state_q == RDB) b_q <= rf_rdata;
      if (state_q == EXEC) begin
        c_q <= alu_y;
        if (loads_q) begin
          n_q <= alu_y[WIDTH-1];
          v_q <= alu_v;
          z_q <= (alu_y == '0);
        end
      end
    end
  end

  assign out = c_q;
  assign N   = n_q;
  assign V   = v_q;
  assign Z   = z_q;

endmodule

// File: tb/tb_dp_seq_core.sv
// Directed self-checking bench for dp_seq_core (WIDTH=16, NREGS=8, PCW=8).
module tb_dp_seq_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_rn, cmd_rm, cmd_rd;
  logic [1:0]  cmd_shift, cmd_aluop, cmd_vsel;
  logic        cmd_asel, cmd_bsel, cmd_wb, cmd_loads;
  logic [15:0] cmd_imm8, cmd_imm5, mdata;
  logic [7:0]  pc;
  logic        done, N, V, Z;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_seq_core #(.WIDTH(16), .NREGS(8), .PCW(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_rd(cmd_rd),
    .cmd_shift(cmd_shift), .cmd_aluop(cmd_aluop),
    .cmd_asel(cmd_asel), .cmd_bsel(cmd_bsel), .cmd_vsel(cmd_vsel),
    .cmd_wb(cmd_wb), .cmd_loads(cmd_loads),
    .cmd_imm8(cmd_imm8), .cmd_imm5(cmd_imm5),
    .mdata(mdata), .pc(pc),
    .done(done), .out(out), .N(N), .V(V), .Z(Z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] rn, rm, rd, input logic [1:0] sh, op,
                       input logic as, bs, input logic [1:0] vs, input logic wb, ld,
                       input logic [15:0] i8, i5);
    cmd_rn = rn; cmd_rm = rm; cmd_rd = rd; cmd_shift = sh; cmd_aluop = op;
    cmd_asel = as; cmd_bsel = bs; cmd_vsel = vs; cmd_wb = wb; cmd_loads = ld;
    cmd_imm8 = i8; cmd_imm5 = i5;
  endtask

  // One command: accept, measure latency to done, confirm done is a single pulse.
  task automatic issue(input string tag, input logic [2:0] rn, rm, rd, input logic [1:0] sh, op,
                       input logic as, bs, input logic [1:0] vs, input logic wb, ld,
                       input logic [15:0] i8, i5, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, " ready"}, cmd_ready, 1);
    drive(rn, rm, rd, sh, op, as, bs, vs, wb, ld, i8, i5);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, done, 0);
  endtask

  // Register readback through the ALU: out = R[rn] + imm5(0), status untouched.
  task automatic rdback(input string tag, input logic [2:0] rn, input logic [15:0] exp);
    issue(tag, rn, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 4);
    chk({tag, " value"}, out, exp);
  endtask

  task automatic flags(input string tag, input logic [2:0] nvz);
    chk({tag, " NVZ"}, {N, V, Z}, nvz);
  endtask

  initial begin
    logic [9:0] rdy_v, done_v;
    int accepts, pulses;

    reset = 1'b1; cmd_valid = 1'b0; mdata = 16'h0; pc = 8'h0;
    drive(3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", cmd_ready, 1);
    chk("reset done", done, 0);
    chk("reset out", out, 16'h0);
    flags("reset", 3'b000);
    reset = 1'b0;

    // Direct writebacks (1-cycle latency)
    issue("ld r0 imm", 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 16'h0007, 16'h0, 1);
    chk("ld r0 out", out, 16'h0000);
    issue("ld r1", 3'd0, 3'd0, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 16'h0002, 16'h0, 1);
    issue("ld r2", 3'd0, 3'd0, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 16'h0003, 16'h0, 1);
    mdata = 16'h7FFF;
    issue("ld r4 mem", 3'd0, 3'd0, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 16'h0, 16'h0, 1);
    issue("ld r5", 3'd0, 3'd0, 3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 16'h0001, 16'h0, 1);
    pc = 8'hA5;
    issue("ld r6 pc", 3'd0, 3'd0, 3'd6, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 16'h0, 16'h0, 1);
    mdata = 16'h8004;
    issue("ld r7 mem", 3'd0, 3'd0, 3'd7, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 16'h0, 16'h0, 1);
    issue("nop wb0", 3'd0, 3'd0, 3'd7, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 16'hDEAD, 16'h0, 1);

    // ADD R1 + (R2<<1) -> R3 = 2 + 6 = 8
    issue("add lsl", 3'd1, 3'd2, 3'd3, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 16'h0, 16'h0, 4);
    chk("add lsl out", out, 16'h0008);
    flags("add lsl", 3'b000);
    rdback("rd r3", 3'd3, 16'h0008);
    rdback("rd r0", 3'd0, 16'h0007);
    rdback("rd r6", 3'd6, 16'h00A5);
    rdback("rd r7", 3'd7, 16'h8004);
    flags("rdback keeps", 3'b000);

    // Signed overflow: 0x7FFF + 1
    issue("add ovf", 3'd4, 3'd5, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 16'h0, 16'h0, 4);
`ifdef DP_SAT_EN
    chk("add ovf out", out, 16'h7FFF);
    flags("add ovf", 3'b010);
`else
    chk("add ovf out", out, 16'h8000);
    flags("add ovf", 3'b110);
`endif

    // SUB R1-R1 with no writeback, then NOT B with loads=0
    issue("sub self", 3'd1, 3'd1, 3'd1, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 16'h0, 16'h0, 4);
    chk("sub self out", out, 16'h0000);
    flags("sub self", 3'b001);
    rdback("rd r1", 3'd1, 16'h0002);
    issue("notb", 3'd0, 3'd0, 3'd0, 2'b00, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0000, 4);
    chk("notb out", out, 16'hFFFF);
    flags("notb keeps", 3'b001);

    // Shifts through the B path with A forced to zero
    issue("asr", 3'd0, 3'd7, 3'd0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 16'h0, 16'h0, 4);
    chk("asr out", out, 16'hC002);
    flags("asr", 3'b100);
    issue("lsr", 3'd0, 3'd7, 3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 16'h0, 16'h0, 4);
    chk("lsr out", out, 16'h4002);
    flags("lsr", 3'b000);
    issue("sub imm", 3'd0, 3'd0, 3'd0, 2'b00, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 16'h0, 16'hFFFF, 4);
    chk("sub imm out", out, 16'h0001);
    flags("sub imm", 3'b000);
    issue("and", 3'd4, 3'd7, 3'd0, 2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 16'h0, 16'h0, 4);
    chk("and out", out, 16'h0004);
    flags("and", 3'b000);

    // SUB overflow: 0x8004 - 0x7FFF -> R5
    issue("sub ovf", 3'd7, 3'd4, 3'd5, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 16'h0, 16'h0, 4);
`ifdef DP_SAT_EN
    chk("sub ovf out", out, 16'h8000);
    flags("sub ovf", 3'b110);
    rdback("rd r5", 3'd5, 16'h8000);
`else
    chk("sub ovf out", out, 16'h0005);
    flags("sub ovf", 3'b010);
    rdback("rd r5", 3'd5, 16'h0005);
`endif

    // cmd_valid held for 10 cycles: two accepts, ready only in IDLE
    @(negedge clk);
    drive(3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    cmd_valid = 1'b1;
    accepts = 0; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      rdy_v[i] = cmd_ready;
      done_v[i] = done;
      if (cmd_ready === 1'b1) accepts++;
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("held ready pattern", rdy_v, 10'b0000100001);
    chk("held done pattern", done_v, 10'b1000010000);
    chk("held accepts", accepts, 2);
    chk("held pulses", pulses, 2);
    chk("held out", out, 16'h000E);

    // Reset during EXEC: aborts, no done
    @(negedge clk);
    drive(3'd1, 3'd2, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 16'h0, 16'h0);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("exec ready", cmd_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort ready", cmd_ready, 1);
    chk("abort done", done, 0);
    chk("abort out", out, 16'h0000);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    chk("abort no pulse", pulses, 0);
    rdback("rd r2 abort", 3'd2, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
